// File: rtl/prescaled_timer.sv
// prescaled_timer: single-channel timer with a programmable prescaler,
// a programmable top (reload) value, up/down counting, continuous or one-shot
// mode, start/stop/clear/load controls, wrap and compare-match event pulses,
// and a registered PWM output.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst        - asynchronous active-low reset
//   start      - pulse: IDLE/DONE -> RUN, prescaler cleared
//   stop       - pulse: -> IDLE, value held (wins over start)
//   clear      - pulse: value to start point (0 up / top down), prescaler 0
//   load       - pulse: value <= load_value
//   load_value - value written by load
//   halt       - level: freeze prescaler and value while in RUN
//   up         - count direction, 1 = up
//   one_shot   - 1 = stop in DONE at the first wrap
//   prescale   - tick every prescale+1 enabled cycles
//   top        - terminal value of the count range 0..top
//   compare    - match / PWM threshold
//   value      - current count
//   running    - 1 while in RUN
//   wrap       - one-cycle pulse on the terminal tick
//   match      - one-cycle pulse when a tick lands on compare
//   pwm        - registered running && (value < compare)
module prescaled_timer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      halt,
  input  logic                      up,
  input  logic                      one_shot,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]          top,
  input  logic [WIDTH-1:0]          compare,
  output logic [WIDTH-1:0]          value,
  output logic                      running,
  output logic                      wrap,
  output logic                      match,
  output logic                      pwm
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]          value_q, value_d;
  logic                      wrap_q, wrap_d;
  logic                      match_q, match_d;
  logic                      pwm_q, pwm_d;

  logic advance;
  logic tick;
  logic at_end;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    value_d = value_q;
    wrap_d  = 1'b0;
    match_d = 1'b0;

    // Counting only advances on cycles free of any control pulse that
    // overrides it (stop, clear, load) and while not halted.
    advance = (state_q == RUN) && !halt && !stop && !clear && !load;
    tick    = advance && (presc_q == prescale);
    at_end  = up ? (value_q >= top) : ((value_q == '0) || (value_q > top));

    if (clear) begin
      value_d = up ? '0 : top;
      presc_d = '0;
    end else if (load) begin
      value_d = load_value;
    end else if (tick) begin
      presc_d = '0;
      wrap_d  = at_end;
      if (at_end) begin
        if (one_shot) begin
          value_d = up ? top : '0;
          state_d = DONE;
        end else begin
          value_d = up ? '0 : top;
        end
      end else begin
        value_d = up ? value_q + WIDTH'(1) : value_q - WIDTH'(1);
      end
      match_d = (value_d == compare);
    end else if (advance) begin
      presc_d = presc_q + PRESCALE_WIDTH'(1);
    end

    // State controls are applied last so start's prescaler clear overrides
    // the hold implied by a simultaneous load.
    if (stop) begin
      state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
      presc_d = '0;
    end

    // Computed from next-state values so pwm lines up with value.
    pwm_d = (state_d == RUN) && (value_d < compare);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      value_q <= '0;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      value_q <= value_d;
      wrap_q  <= wrap_d;
      match_q <= match_d;
      pwm_q   <= pwm_d;
    end
  end

  assign value   = value_q;
  assign running = (state_q == RUN);
  assign wrap    = wrap_q;
  assign match   = match_q;
  assign pwm     = pwm_q;

endmodule

// File: tb/tb_prescaled_timer.sv
module tb_prescaled_timer;

  logic        clk;
  logic        rst;
  logic        start, stop, clear, load, halt, up, one_shot;
  logic [15:0] load_value, top, compare;
  logic [7:0]  prescale;
  logic [15:0] value;
  logic        running, wrap, match, pwm;

  int checks = 0;
  int errors = 0;

  prescaled_timer #(.WIDTH(16), .PRESCALE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_value(load_value), .halt(halt), .up(up),
    .one_shot(one_shot), .prescale(prescale), .top(top), .compare(compare),
    .value(value), .running(running), .wrap(wrap), .match(match), .pwm(pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: timer behaviour from its rules, in plain integers.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mmode_e;
  mmode_e m_mode;
  int     m_pre, m_val;
  bit     m_wrap, m_match, m_pwm;

  task automatic model_reset();
    m_mode = M_IDLE; m_pre = 0; m_val = 0;
    m_wrap = 0; m_match = 0; m_pwm = 0;
  endtask

  task automatic model_edge();
    mmode_e old_mode;
    bit     counting, finished;
    if (!rst) begin
      model_reset();
      return;
    end
    old_mode = m_mode;
    m_wrap = 0;
    m_match = 0;
    counting = (old_mode == M_RUN) && !halt && !stop && !clear && !load;
    if (clear) begin
      m_val = up ? 0 : int'(top);
      m_pre = 0;
    end else if (load) begin
      m_val = int'(load_value);
    end else if (counting) begin
      if (m_pre == int'(prescale)) begin
        m_pre = 0;
        if (up) finished = (m_val >= int'(top));
        else    finished = (m_val == 0) || (m_val > int'(top));
        if (finished) begin
          m_wrap = 1;
          if (one_shot) begin
            m_val  = up ? int'(top) : 0;
            m_mode = M_DONE;
          end else begin
            m_val = up ? 0 : int'(top);
          end
        end else begin
          m_val = (up ? m_val + 1 : m_val - 1) % 65536;
        end
        m_match = (m_val == int'(compare));
      end else begin
        m_pre = m_pre + 1;
      end
    end
    if (stop) m_mode = M_IDLE;
    else if (start && old_mode != M_RUN) begin
      m_mode = M_RUN;
      m_pre  = 0;
    end
    m_pwm = (m_mode == M_RUN) && (m_val < int'(compare));
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk5(input string name, input int v, input bit r, input bit w,
                      input bit m, input bit p);
    check({name, "_value"},   value,   v);
    check({name, "_running"}, running, r);
    check({name, "_wrap"},    wrap,    w);
    check({name, "_match"},   match,   m);
    check({name, "_pwm"},     pwm,     p);
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr_pulses();
    start = 0; stop = 0; clear = 0; load = 0; halt = 0;
  endtask

  task automatic do_reset();
    clr_pulses();
    rst = 0;
    model_reset();
    #20;
    rst = 1;
  endtask

  typedef struct {
    bit st, sp, cl, ld, ht;
    int v;
    bit r, w, m, p;
  } vec_t;

  function automatic vec_t mk(bit st, bit sp, bit cl, bit ld, bit ht,
                              int v, bit r, bit w, bit m, bit p);
    vec_t t;
    t.st = st; t.sp = sp; t.cl = cl; t.ld = ld; t.ht = ht;
    t.v = v; t.r = r; t.w = w; t.m = m; t.p = p;
    return t;
  endfunction

  vec_t tbl[18];

  initial begin
    // start stop clear load halt | value running wrap match pwm
    tbl[0]  = mk(1,0,0,0,0, 0,1,0,0,1);
    tbl[1]  = mk(0,0,0,0,0, 1,1,0,0,1);
    tbl[2]  = mk(0,0,0,0,0, 2,1,0,0,1);
    tbl[3]  = mk(0,0,0,0,0, 3,1,0,0,1);
    tbl[4]  = mk(0,0,0,0,0, 4,1,0,0,1);
    tbl[5]  = mk(0,0,0,0,0, 0,1,1,0,1);
    tbl[6]  = mk(0,0,0,0,0, 1,1,0,0,1);
    tbl[7]  = mk(0,0,0,0,0, 2,1,0,0,1);
    tbl[8]  = mk(0,0,0,0,0, 3,1,0,0,1);
    tbl[9]  = mk(0,0,0,0,0, 4,1,0,0,1);
    tbl[10] = mk(0,0,0,0,0, 0,1,1,0,1);
    tbl[11] = mk(0,1,0,0,1, 0,0,0,0,0);
    tbl[12] = mk(0,0,0,0,0, 0,0,0,0,0);
    tbl[13] = mk(0,0,1,0,0, 0,0,0,0,0);
    tbl[14] = mk(0,0,0,1,0, 3,0,0,0,0);
    tbl[15] = mk(1,0,0,0,0, 3,1,0,0,1);
    tbl[16] = mk(0,0,0,0,0, 4,1,0,0,1);
    tbl[17] = mk(0,0,0,0,0, 0,1,1,0,1);

    up = 1; one_shot = 0; prescale = 0; top = 4; compare = 16'hFFFF;
    load_value = 3;
    do_reset();
    chk5("reset", 0, 0, 0, 0, 0);
    cycle();
    chk5("reset_idle", 0, 0, 0, 0, 0);

    // Test 1: continuous up count, top=4
    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl;
      load = tbl[i].ld; halt = tbl[i].ht;
      cycle();
      clr_pulses();
      chk5($sformatf("t1_vec%0d", i), tbl[i].v, tbl[i].r, tbl[i].w, tbl[i].m, tbl[i].p);
    end

    // Test 2: one-shot down count with prescale=3
    do_reset();
    prescale = 3; top = 2; up = 0; one_shot = 1; compare = 7;
    clear = 1; cycle(); clear = 0;
    chk5("t2_clear", 2, 0, 0, 0, 0);
    start = 1; cycle(); start = 0;
    chk5("t2_start", 2, 1, 0, 0, 1);
    for (int s = 1; s >= 0; s--) begin
      repeat (3) begin
        cycle();
        check("t2_hold", value, s + 1);
      end
      cycle();
      chk5("t2_step", s, 1, 0, 0, 1);
    end
    repeat (3) begin
      cycle();
      chk5("t2_pre_wrap", 0, 1, 0, 0, 1);
    end
    cycle();
    chk5("t2_wrap", 0, 0, 1, 0, 0);
    repeat (3) begin
      cycle();
      chk5("t2_done", 0, 0, 0, 0, 0);
    end
    one_shot = 0;

    // Test 3: compare match and pwm, top=9 compare=3
    do_reset();
    prescale = 0; top = 9; compare = 3; up = 1;
    start = 1; cycle(); start = 0;
    chk5("t3_start", 0, 1, 0, 0, 1);
    for (int i = 1; i <= 22; i++) begin
      int v;
      v = i % 10;
      cycle();
      chk5("t3_run", v, 1, v == 0, v == 3, v < 3);
    end
    stop = 1; halt = 1; cycle(); clr_pulses();
    chk5("t3_stop", 2, 0, 0, 0, 0);

    // Test 4: halt, clear beats load, then load alone
    do_reset();
    compare = 20; top = 9;
    start = 1; cycle(); start = 0;
    repeat (7) cycle();
    check("t4_at7", value, 7);
    halt = 1;
    repeat (5) begin
      cycle();
      chk5("t4_halt", 7, 1, 0, 0, 1);
    end
    halt = 0; clear = 1; load = 1; load_value = 5;
    cycle(); clr_pulses();
    chk5("t4_clr_ld", 0, 1, 0, 0, 1);
    load = 1; cycle(); load = 0;
    chk5("t4_load", 5, 1, 0, 0, 1);
    cycle(); chk5("t4_after6", 6, 1, 0, 0, 1);
    cycle(); chk5("t4_after7", 7, 1, 0, 0, 1);

    // Test 5: top lowered below value, then start+stop from IDLE
    do_reset();
    top = 9; compare = 20;
    start = 1; cycle(); start = 0;
    repeat (8) cycle();
    check("t5_at8", value, 8);
    top = 3;
    cycle(); chk5("t5_wrap", 0, 1, 1, 0, 1);
    cycle(); chk5("t5_next", 1, 1, 0, 0, 1);
    stop = 1; halt = 1; cycle(); clr_pulses();
    chk5("t5_stopped", 1, 0, 0, 0, 0);
    start = 1; stop = 1; cycle(); clr_pulses();
    chk5("t5_start_stop", 1, 0, 0, 0, 0);
    cycle(); chk5("t5_still_idle", 1, 0, 0, 0, 0);

    // Test 6: asynchronous reset between edges
    do_reset();
    top = 9; compare = 20;
    start = 1; cycle(); start = 0;
    repeat (3) cycle();
    chk5("t6_pre", 3, 1, 0, 0, 1);
    #2 rst = 0;
    model_reset();
    #1 chk5("t6_async", 0, 0, 0, 0, 0);
    cycle();
    chk5("t6_held", 0, 0, 0, 0, 0);
    #2 rst = 1;
    repeat (3) begin
      cycle();
      chk5("t6_idle", 0, 0, 0, 0, 0);
    end
    start = 1; cycle(); start = 0;
    chk5("t6_start", 0, 1, 0, 0, 1);
    cycle(); chk5("t6_count", 1, 1, 0, 0, 1);

    // Randomized run against the reference model
    do_reset();
    top = 6; prescale = 1; compare = 4; up = 1; one_shot = 0;
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(31) == 0);
      clear = ($urandom_range(39) == 0);
      load  = ($urandom_range(39) == 0);
      halt  = ($urandom_range(5) == 0);
      load_value = 16'($urandom_range(15));
      if ($urandom_range(49) == 0) up = ~up;
      if ($urandom_range(99) == 0) one_shot = ~one_shot;
      if ($urandom_range(99) == 0) top = 16'($urandom_range(12));
      if ($urandom_range(59) == 0) prescale = 8'($urandom_range(3));
      if ($urandom_range(39) == 0) compare = 16'($urandom_range(14));
      cycle();
      check("rnd_value",   value,   m_val);
      check("rnd_running", running, m_mode == M_RUN);
      check("rnd_wrap",    wrap,    m_wrap);
      check("rnd_match",   match,   m_match);
      check("rnd_pwm",     pwm,     m_pwm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_timer.md
Name: prescaled_timer

Overview:
Parametrised successor to the basic free-running counter. It is a single-channel timer with the following features:
- programmable prescaler and programmable top (reload) value
- up or down direction
- continuous or one-shot mode
- start/stop/clear/load controls
- wrap and compare-match event pulses, plus a PWM output

It sits beside the bus-facing peripheral registers. The register block drives the config/control inputs and samples the status outputs.

Parameters:
WIDTH, 16, width of the count value, top, compare and load values
PRESCALE_WIDTH, 8, width of the prescaler divisor

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  pulse: begin counting (IDLE/DONE -> RUN)
stop  input  1  pulse: stop counting, hold value (-> IDLE)
clear  input  1  pulse: value to start point, prescaler to 0
load  input  1  pulse: value <= load_value
load_value  input  WIDTH  value written by load
halt  input  1  level: freeze prescaler and value while in RUN
up  input  1  1 = count up, 0 = count down
one_shot  input  1  1 = stop at first wrap, 0 = continuous
prescale  input  PRESCALE_WIDTH  tick every prescale+1 enabled cycles
top  input  WIDTH  terminal value of the count range 0..top
compare  input  WIDTH  compare/PWM threshold
value  output  WIDTH  current count
running  output  1  1 while in RUN
wrap  output  1  one-cycle pulse on terminal tick
match  output  1  one-cycle pulse when a tick lands on compare
pwm  output  1  registered, (value < compare) while running, else 0

Behaviour:
- Reset (rst=0, async):
  - state IDLE, prescaler=0, value=0
  - running=0, wrap=0, match=0, pwm=0
- States:
  - IDLE: value held, no ticks
  - RUN: counting
  - DONE: one-shot finished, value held at terminal
- Transitions:
  - IDLE/DONE + start -> RUN, prescaler cleared
  - RUN + stop -> IDLE
  - start and stop in same cycle: stop wins
  - start while already in RUN: ignored
- Prescaler: in RUN with halt=0, increments each cycle. When prescaler==prescale it generates a tick and returns to 0. prescale=0 gives a tick every cycle.
- halt=1 in RUN: prescaler and value frozen, no events, state unchanged.
- Tick, up=1:
  - value>=top: value<=0 and wrap=1.
  - else: value<=value+1.
  - The >= check means that if top is lowered below value, the next tick wraps.
- Tick, up=0:
  - value==0 or value>top: value<=top and wrap=1.
  - else: value<=value-1.
- One-shot: on the wrapping tick, state -> DONE and wrap=1. value holds the terminal value (top when up, 0 when down) instead of reloading.
- match=1 for one cycle when a tick's new value equals compare. The compare is registered on the same edge as value.
- pwm is updated every cycle as running && (value<compare). compare=0 gives constant 0; compare>top gives constant 1 while running.
- Control priority within one cycle: clear > load > tick.
  - clear: value <= (up ? 0 : top), prescaler<=0, state unchanged, no wrap/match.
  - load: value<=load_value, prescaler unchanged, no events.
- Latency: a control pulse takes effect on the next rising edge. The first tick after start occurs prescale+1 cycles after the start edge.
- Direction or top changes mid-run take effect at the next tick. There is no restart.
- All arithmetic is modulo 2^WIDTH. There is no carry out beyond wrap.
- Outputs are registered, with no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then WIDTH=16, prescale=0, top=4, up=1, continuous, start -> value 0,1,2,3,4,0,…; wrap pulses on the 4->0 edge every 5 cycles; running=1.
2. prescale=3, top=2, up=0, one_shot=1, clear then start -> value 2,1,0 with 4 cycles per step; a further 4 cycles later, wrap pulses once, state DONE, value holds 0, running=0.
3. prescale=0, top=9, compare=3, up=1, run -> match pulses when value becomes 3; pwm=1 for values 0..2 and 0 for 3..9; pwm=0 after stop.
4. Mid-run at value 7 (top=9): halt high 5 cycles -> value stays 7, no events. Then in one cycle assert clear+load (load_value=5) -> value=0 (clear wins). Next, load alone with 5 -> value 5, counting resumes 6,7.
5. Running up at value 8, top changed to 3 -> next tick gives value 0 with wrap=1. start+stop in same cycle from IDLE -> stays IDLE.
6. Assert rst low asynchronously mid-count (between edges) -> all outputs 0 immediately. Release -> IDLE, value 0, no tick until start.
